// File: rtl/pc_update.sv
//==============================================================================
//  Module   : pc_update
//  Purpose  : Next-PC stage. Holds the architectural PC, requests fetches from
//             the IFU over a valid/ready handshake, takes finished instructions
//             from execute, and computes
//                 next pc = (pc_a_src ? imm : 4) + (pc_b_src ? rs1 : pc)
//             with the JALR bit-0 rule. A target that is not 4-byte aligned
//             redirects to trap_vec and raises a one-cycle misalign_trap pulse.
//  Ports    :
//    clk, rst_n          - clock, asynchronous active-low reset
//    pc_a_src, pc_b_src  - adder select bits from the branch-condition decoder
//    imm, rs1, is_jalr   - adder operands and JALR bit-0 clear
//    commit_valid/ready  - commit handshake with execute
//    ifu_req_valid/ready - fetch handshake with the IFU; ifu_pc = pc
//    pc                  - architectural PC
//    trap_vec            - trap base (4-byte aligned)
//    misalign_trap       - one-cycle pulse after a misaligned redirect
//    dbg_idx, dbg_pc     - redirect-history read port
//  Options  : PC_UPDATE_HISTORY_EN builds a HIST_DEPTH-entry ring buffer of the
//             old pc of every redirect; without it dbg_pc is tied to 0.
//  Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module pc_update #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h8000_0000,
  parameter int                HIST_DEPTH   = 4   // power of 2, >= 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pc_a_src,
  input  logic                          pc_b_src,
  input  logic [XLEN-1:0]               imm,
  input  logic [XLEN-1:0]               rs1,
  input  logic                          is_jalr,
  input  logic                          commit_valid,
  output logic                          commit_ready,
  output logic                          ifu_req_valid,
  input  logic                          ifu_req_ready,
  output logic [XLEN-1:0]               ifu_pc,
  output logic [XLEN-1:0]               pc,
  input  logic [XLEN-1:0]               trap_vec,
  output logic                          misalign_trap,
  input  logic [$clog2(HIST_DEPTH)-1:0] dbg_idx,
  output logic [XLEN-1:0]               dbg_pc
);

  //--------------------------------------------------------------------------
  // State encoding
  //--------------------------------------------------------------------------
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [XLEN-1:0] C_INCR = XLEN'(4);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_trap_q, misalign_trap_d;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] sum;
  logic            misaligned;
  logic            commit_fire;

  //--------------------------------------------------------------------------
  // State register (process 1 of 3)
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic (process 2 of 3)
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      // One settle cycle after reset release; no request is issued here.
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (ifu_req_ready) state_d = S_EXEC;
      S_EXEC:  if (commit_valid)  state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
  end

  //--------------------------------------------------------------------------
  // Output logic (process 3 of 3). Both handshake outputs decode straight
  // from the state flop, so reset removes them asynchronously.
  //--------------------------------------------------------------------------
  always_comb begin
    ifu_req_valid = 1'b0;
    commit_ready  = 1'b0;
    case (state_q)
      S_FETCH: ifu_req_valid = 1'b1;
      S_EXEC:  commit_ready  = 1'b1;
      default: ;
    endcase
  end

  //--------------------------------------------------------------------------
  // Next-PC datapath
  //--------------------------------------------------------------------------
  assign commit_fire = commit_valid & commit_ready;

  always_comb begin
    op_a = pc_a_src ? imm : C_INCR;
    op_b = pc_b_src ? rs1 : pc_q;
    sum  = op_a + op_b;            // modulo 2^XLEN, carry dropped
    if (is_jalr) begin
      sum[0] = 1'b0;
    end
    misaligned = |sum[1:0];
  end

  // pc only moves on a commit, which can only happen in EXEC, so ifu_pc is
  // guaranteed stable for the whole time a fetch request is outstanding.
  always_comb begin
    pc_d            = pc_q;
    misalign_trap_d = 1'b0;
    if (commit_fire) begin
      if (misaligned) begin
        pc_d            = trap_vec;
        misalign_trap_d = 1'b1;
      end else begin
        pc_d            = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_VECTOR;
      misalign_trap_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      misalign_trap_q <= misalign_trap_d;
    end
  end

  assign pc            = pc_q;
  assign ifu_pc        = pc_q;
  assign misalign_trap = misalign_trap_q;

  //--------------------------------------------------------------------------
  // Redirect history
  //--------------------------------------------------------------------------
`ifdef PC_UPDATE_HISTORY_EN
  localparam int IDX_W = $clog2(HIST_DEPTH);

  logic [XLEN-1:0]  hist_q [HIST_DEPTH];
  logic [XLEN-1:0]  hist_d [HIST_DEPTH];
  logic [IDX_W-1:0] wptr_q, wptr_d;
  logic [IDX_W-1:0] rd_idx;
  logic             redirect;

  // Anything other than fall-through, traps included, counts as a redirect.
  assign redirect = commit_fire & (pc_d != (pc_q + C_INCR));

  always_comb begin
    hist_d = hist_q;
    wptr_d = wptr_q;
    if (redirect) begin
      hist_d[wptr_q] = pc_q;       // oldest entry is overwritten on wrap
      wptr_d         = wptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      hist_q <= hist_d;
    end
  end

  // Index 0 is the most recent redirect; the IDX_W-bit subtraction wraps
  // naturally because HIST_DEPTH is a power of two.
  assign rd_idx = wptr_q - IDX_W'(1) - dbg_idx;
  assign dbg_pc = hist_q[rd_idx];
`else
  logic unused_dbg_idx;
  assign unused_dbg_idx = ^dbg_idx;
  assign dbg_pc         = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pc_update.md
Name: pc_update

Overview:
- Sequential next-PC stage that sits directly downstream of the branch-condition decoder and consumes its two adder-select bits.
- Holds the architectural PC register and computes next PC = (A-select ? imm : 4) + (B-select ? rs1 : pc).
- Issues fetch requests to the IFU through a valid/ready handshake and sequences fetch → execute → commit.
- Redirects to a trap vector when the computed target is misaligned.

Parameters:
- RESET_VECTOR, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, PC/operand width.
- HIST_DEPTH, 4, redirect-history entries (power of 2); used only when the optional feature is enabled.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_a_src  in  1  0: adder A = 4; 1: adder A = imm.
- pc_b_src  in  1  0: adder B = pc; 1: adder B = rs1.
- imm  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  rs1 register value.
- is_jalr  in  1  clear bit 0 of the sum (JALR rule).
- commit_valid  in  1  execute stage presents a finished instruction; selects/operands are stable while high.
- commit_ready  out  1  this block accepts the commit.
- ifu_req_valid  out  1  fetch request for ifu_pc.
- ifu_req_ready  in  1  IFU accepts the request.
- ifu_pc  out  XLEN  fetch address (equals pc).
- pc  out  XLEN  architectural PC.
- trap_vec  in  XLEN  mtvec base; must be 4-byte aligned.
- misalign_trap  out  1  one-cycle pulse on a misaligned-target redirect.
- dbg_idx  in  log2(HIST_DEPTH)  history read index.
- dbg_pc  out  XLEN  history read data.

Behaviour:
- Reset (asynchronous, rst_n low): pc = RESET_VECTOR, state = BOOT, ifu_req_valid = 0, commit_ready = 0, misalign_trap = 0, history cleared, dbg_pc = 0.
- BOOT: lasts exactly one cycle after reset release, then goes to FETCH. Allows reset synchronisers to settle; no request is issued.
- FETCH: ifu_req_valid = 1 and ifu_pc = pc.
  - Stay in FETCH until ifu_req_ready = 1; the handshake completes in that cycle and the state moves to EXEC.
  - ifu_pc must not change while valid is high and ready is low.
- EXEC: commit_ready = 1 (combinational from state) and ifu_req_valid = 0.
  - On commit_valid & commit_ready, latch sum = A + B. Arithmetic is XLEN-bit modulo; carry out is discarded, and wrap from 0xFFFF_FFFC + 4 gives 0.
  - If is_jalr, clear sum[0].
  - If sum[1:0] != 0 after that: pc <= trap_vec and misalign_trap = 1 for exactly that edge's following cycle. Otherwise pc <= sum.
  - State moves to FETCH on the next cycle. Latency is commit handshake → new ifu_req_valid = 1 cycle.
- Selects {a,b} = 00 give the sequential pc+4; 10 gives a branch/JAL target; 11 gives rs1+imm. Combination 01 (rs1+4) is legal and computed as stated.
- commit_valid while in FETCH or BOOT is ignored (commit_ready = 0).
- Asserting rst_n low mid-handshake aborts at once: ifu_req_valid drops asynchronously and no commit is taken.
- A redirect is any commit whose new pc != old pc + 4; it is recorded by the optional feature only.

Optional Feature:
- Macro: PC_UPDATE_HISTORY_EN.
- Defined: a HIST_DEPTH-entry ring buffer records the old pc of every redirect, including traps.
  - Write pointer wraps modulo HIST_DEPTH and the oldest entry is overwritten.
  - dbg_pc = entry[(wptr - 1 - dbg_idx) mod HIST_DEPTH], so dbg_idx = 0 is the most recent redirect.
  - Entries never written read 0.
- Undefined: no buffer or pointer logic is built and dbg_pc is tied to 0.

Test Plan:
- Reset release, ifu_req_ready held 1 → BOOT for 1 cycle, then ifu_req_valid = 1 with ifu_pc = 0x8000_0000. Commit with sel 00 → pc = 0x8000_0004.
- ifu_req_ready low for 3 cycles → ifu_req_valid and ifu_pc stay stable all 3 cycles. The handshake completes when ready rises; commit_ready goes to 1 on the next cycle.
- pc = 0x8000_0010, sel 10, imm = 0xFFFF_FFF0 → pc = 0x8000_0000. With history enabled, dbg_idx = 0 gives dbg_pc = 0x8000_0010.
- sel 11, is_jalr = 1, rs1 = 0x8000_0101, imm = 3 → sum 0x8000_0104, bit0 cleared, pc = 0x8000_0104, no trap.
- sel 11, is_jalr = 0, rs1 = 0x8000_0002, imm = 0, trap_vec = 0x8000_1000 → pc = 0x8000_1000 and misalign_trap pulses for exactly 1 cycle.
- rst_n low while in FETCH with ready = 0 → ifu_req_valid drops immediately and pc = 0x8000_0000. With history enabled, 5 redirects wrap the buffer and dbg_idx = 3 returns the 2nd redirect's pc.
